// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and defaults for the unified memory port arbiter
package mem_port_arbiter_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int MEM_AW_DEF = 14;

  // Requester identity, also carried in the read-response tag
  typedef enum logic [1:0] {
    SRC_I = 2'd0,
    SRC_D = 2'd1,
    SRC_L = 2'd2
  } src_t;

  typedef struct packed {
    logic valid;
    src_t src;
  } rsp_tag_t;

endpackage

// File: rtl/mem_rsp_tag_pipe.sv
// rtl/mem_rsp_tag_pipe.sv - RD_LAT-deep {valid,src} shift pipe matching SRAM read latency
module mem_rsp_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rsp_tag_t push_tag,
  output rsp_tag_t pop_tag
);

  rsp_tag_t stage [RD_LAT];

  // Advance tags one stage per cycle; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LAT; k++) stage[k] <= '0;
    end else begin
      stage[0] <= push_tag;
      for (int k = 1; k < RD_LAT; k++) stage[k] <= stage[k-1];
    end
  end

  assign pop_tag = stage[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - I/D (optional loader, macro LOADER_PORT_EN) arbiter onto one single-port SRAM
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_W   = WORD_W_DEF,
  parameter int MEM_AW   = MEM_AW_DEF,
  parameter int RD_LAT   = 1,
  parameter int I_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [WORD_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [WORD_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [WORD_W-1:0] d_rdata,
`ifdef LOADER_PORT_EN
  input  logic              l_req,
  input  logic [WORD_W-1:0] l_addr,
  input  logic [WORD_W-1:0] l_wdata,
  output logic              l_gnt,
`endif
  output logic              m_en,
  output logic              m_we,
  output logic [MEM_AW-1:0] m_addr,
  output logic [WORD_W-1:0] m_wdata,
  input  logic [WORD_W-1:0] m_rdata
);

  localparam int SW = (I_STARVE < 1) ? 1 : $clog2(I_STARVE + 1);

  logic              ld_req;
  logic [WORD_W-1:0] ld_addr;
  logic [WORD_W-1:0] ld_wdata;
  logic              ld_gnt;

`ifdef LOADER_PORT_EN
  assign ld_req   = l_req;
  assign ld_addr  = l_addr;
  assign ld_wdata = l_wdata;
  assign l_gnt    = ld_gnt;
`else
  assign ld_req   = 1'b0;
  assign ld_addr  = '0;
  assign ld_wdata = '0;
`endif

  src_t              rr_last;
  logic [SW-1:0]     starve_cnt;
  logic              l_win, i_win, d_win;
  logic [WORD_W-1:0] sel_addr;
  logic              unused_addr;
  rsp_tag_t          push_tag, pop_tag;
  logic [WORD_W-1:0] i_hold, d_hold;

  // Pick at most one winner: loader first, then round-robin with I starvation override
  always_comb begin
    l_win = 1'b0;
    i_win = 1'b0;
    d_win = 1'b0;
    if (ld_req) begin
      l_win = 1'b1;
    end else if (i_req && d_req) begin
      if (starve_cnt == SW'(I_STARVE) || rr_last == SRC_D) i_win = 1'b1;
      else                                                 d_win = 1'b1;
    end else begin
      i_win = i_req;
      d_win = d_req;
    end
  end

  // Grants are suppressed while reset is held so the SRAM sees no access
  assign ld_gnt = l_win & rst_n;
  assign i_gnt  = i_win & rst_n;
  assign d_gnt  = d_win & rst_n;

  // Steer the winning port onto the SRAM pins
  always_comb begin
    sel_addr = '0;
    m_wdata  = '0;
    if (ld_gnt) begin
      sel_addr = ld_addr;
      m_wdata  = ld_wdata;
    end else if (i_gnt) begin
      sel_addr = i_addr;
    end else if (d_gnt) begin
      sel_addr = d_addr;
      m_wdata  = d_we ? d_wdata : '0;
    end
  end

  assign m_en   = ld_gnt | i_gnt | d_gnt;
  assign m_we   = ld_gnt | (d_gnt & d_we);
  assign m_addr = sel_addr[MEM_AW+1:2];
  // Byte offset and bits above the SRAM depth alias away
  assign unused_addr = ^{sel_addr[1:0], sel_addr >> (MEM_AW + 2)};

  // Fairness state: last I/D winner and D grants taken while I waited; loader leaves both alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last    <= SRC_D;
      starve_cnt <= '0;
    end else begin
      if (i_gnt)      rr_last <= SRC_I;
      else if (d_gnt) rr_last <= SRC_D;
      if (i_gnt || !i_req)                          starve_cnt <= '0;
      else if (d_gnt && starve_cnt != SW'(I_STARVE)) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign push_tag.valid = i_gnt | (d_gnt & ~d_we);
  assign push_tag.src   = i_gnt ? SRC_I : SRC_D;

  mem_rsp_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_tag (push_tag),
    .pop_tag  (pop_tag)
  );

  assign i_rvalid = pop_tag.valid && (pop_tag.src == SRC_I);
  assign d_rvalid = pop_tag.valid && (pop_tag.src == SRC_D);

  // Remember each port's last returned word so its rdata is stable between responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_hold <= '0;
      d_hold <= '0;
    end else begin
      if (i_rvalid) i_hold <= m_rdata;
      if (d_rvalid) d_hold <= m_rdata;
    end
  end

  assign i_rdata = i_rvalid ? m_rdata : i_hold;
  assign d_rdata = d_rvalid ? m_rdata : d_hold;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter (RD_LAT=1 and RD_LAT=3 instances)
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MEM_AW   = 14;
  localparam int RD_LAT   = 1;
  localparam int I_STARVE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int k);
    return 32'hA500_0000 ^ (k * 32'h0001_0003);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[MEM_AW+1:2]);
  endfunction

  // ---------------- main DUT (RD_LAT=1) ----------------
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, l_req = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, l_addr = '0, l_wdata = '0;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, m_we, l_gnt_s;
  logic [31:0] i_rdata, d_rdata, m_wdata, m_rdata;
  logic [MEM_AW-1:0] m_addr;
`ifdef LOADER_PORT_EN
  logic l_gnt;
  assign l_gnt_s = l_gnt;
`else
  assign l_gnt_s = 1'b0;
`endif

  mem_port_arbiter #(.WORD_W(32), .MEM_AW(MEM_AW), .RD_LAT(RD_LAT), .I_STARVE(I_STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
`ifdef LOADER_PORT_EN
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
`endif
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  logic [31:0] sram    [2**MEM_AW];
  logic [31:0] ref_mem [2**MEM_AW];
  logic [31:0] rd_q = '0;
  assign m_rdata = rd_q;

  always @(posedge clk) begin
    if (m_en && m_we) sram[m_addr] <= m_wdata;
    rd_q <= (m_en && !m_we) ? sram[m_addr] : 32'h0BAD_0BAD;
  end

  // ---------------- second DUT (RD_LAT=3) for reset-in-flight ----------------
  logic        rst3_n = 1'b0;
  logic        i3_req = 1'b0, d3_req = 1'b0;
  logic [31:0] i3_addr = '0;
  logic        i3_gnt, i3_rvalid, d3_gnt, d3_rvalid, m3_en, m3_we;
  logic [31:0] i3_rdata, d3_rdata, m3_wdata, m3_rdata;
  logic [MEM_AW-1:0] m3_addr;
`ifdef LOADER_PORT_EN
  logic l3_gnt;
`endif

  mem_port_arbiter #(.WORD_W(32), .MEM_AW(MEM_AW), .RD_LAT(3), .I_STARVE(I_STARVE)) dut3 (
    .clk(clk), .rst_n(rst3_n),
    .i_req(i3_req), .i_addr(i3_addr), .i_gnt(i3_gnt), .i_rvalid(i3_rvalid), .i_rdata(i3_rdata),
    .d_req(d3_req), .d_we(1'b0), .d_addr(32'h0000_0100), .d_wdata(32'h0),
    .d_gnt(d3_gnt), .d_rvalid(d3_rvalid), .d_rdata(d3_rdata),
`ifdef LOADER_PORT_EN
    .l_req(1'b0), .l_addr(32'h0), .l_wdata(32'h0), .l_gnt(l3_gnt),
`endif
    .m_en(m3_en), .m_we(m3_we), .m_addr(m3_addr), .m_wdata(m3_wdata), .m_rdata(m3_rdata)
  );

  logic [31:0] sram3 [2**MEM_AW];
  logic [31:0] rd3 [3];
  assign m3_rdata = rd3[2];

  always @(posedge clk) begin
    if (m3_en && m3_we) sram3[m3_addr] <= m3_wdata;
    rd3[0] <= (m3_en && !m3_we) ? sram3[m3_addr] : 32'h0BAD_0BAD;
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    bit          src_d;
    logic [31:0] data;
    int          due;
  } sb_t;
  sb_t q[$];

  bit          mon_on = 0, rr_forced = 0;
  bit          m_rr = 1'b1;            // 1 = D granted last
  int          m_starve = 0;
  int          cyc = 0;
  logic        g_i = 0, g_d = 0, g_l = 0;
  logic [31:0] h_i = '0, h_d = '0;

  // Predict each cycle's grant and SRAM drive, push read expectations, retire responses
  always @(negedge clk) begin
    if (mon_on) begin
      logic e_l, e_i, e_d;
      sb_t  e;
      cyc++;
      e_l = l_req; e_i = 1'b0; e_d = 1'b0;
      if (!e_l) begin
        if (i_req && d_req) begin
          if (m_starve == I_STARVE || m_rr) e_i = 1'b1;
          else                              e_d = 1'b1;
        end else begin
          e_i = i_req;
          e_d = d_req;
        end
      end
      if (i_req || d_req || l_req || m_en) begin
        check("i_gnt", {31'b0, i_gnt}, {31'b0, e_i});
        check("d_gnt", {31'b0, d_gnt}, {31'b0, e_d});
        check("l_gnt", {31'b0, l_gnt_s}, {31'b0, e_l});
        check("m_en",  {31'b0, m_en}, {31'b0, e_l | e_i | e_d});
      end
      g_i = i_gnt; g_d = d_gnt; g_l = l_gnt_s;
      if (e_l) begin
        check("l_m_we", {31'b0, m_we}, 32'd1);
        check("l_m_addr", {18'b0, m_addr}, widx(l_addr));
        check("l_m_wdata", m_wdata, l_wdata);
        ref_mem[widx(l_addr)] = l_wdata;
      end else if (e_i) begin
        check("i_m_we", {31'b0, m_we}, 32'd0);
        check("i_m_addr", {18'b0, m_addr}, widx(i_addr));
        q.push_back('{src_d: 1'b0, data: ref_mem[widx(i_addr)], due: cyc + RD_LAT});
      end else if (e_d) begin
        check("d_m_we", {31'b0, m_we}, {31'b0, d_we});
        check("d_m_addr", {18'b0, m_addr}, widx(d_addr));
        if (d_we) begin
          check("d_m_wdata", m_wdata, d_wdata);
          ref_mem[widx(d_addr)] = d_wdata;
        end else begin
          q.push_back('{src_d: 1'b1, data: ref_mem[widx(d_addr)], due: cyc + RD_LAT});
        end
      end
      if (!rr_forced) begin
        if (e_i)      m_rr = 1'b0;
        else if (e_d) m_rr = 1'b1;
      end
      if (e_i || !i_req)                      m_starve = 0;
      else if (e_d && m_starve != I_STARVE)   m_starve++;

      if (i_rvalid || d_rvalid) begin
        if (q.size() == 0) begin
          check("rvalid_spurious", {30'b0, i_rvalid, d_rvalid}, 32'd0);
        end else begin
          e = q.pop_front();
          check("rsp_port", {30'b0, i_rvalid, d_rvalid}, e.src_d ? 32'd1 : 32'd2);
          check("rsp_data", e.src_d ? d_rdata : i_rdata, e.data);
          check("rsp_cycle", cyc, e.due);
          if (e.src_d) begin
            check("i_rdata_hold", i_rdata, h_i);
            h_d = e.data;
          end else begin
            check("d_rdata_hold", d_rdata, h_d);
            h_i = e.data;
          end
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        check("rvalid_missing", 32'd0, 32'd1);
        void'(q.pop_front());
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Hold outstanding requests until granted, with a cycle budget
  task automatic settle();
    for (int n = 0; n < 20; n++) begin
      cycle();
      if (g_i) i_req = 1'b0;
      if (g_d) d_req = 1'b0;
      if (g_l) l_req = 1'b0;
      if (!i_req && !d_req && !l_req) return;
    end
    check("settle_timeout", {29'b0, i_req, d_req, l_req}, 32'd0);
    i_req = 1'b0; d_req = 1'b0; l_req = 1'b0;
  endtask

  // Both ports held busy; each port moves to a new address after its grant
  task automatic both_busy(input int n);
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    for (int k = 0; k < n; k++) begin
      cycle();
      if (g_i) i_addr = i_addr + 32'd4;
      if (g_d) d_addr = d_addr + 32'd4;
    end
    settle();
  endtask

  initial begin
    int lat;
    bit seen;
    for (int k = 0; k < 2**MEM_AW; k++) begin
      sram[k] = init_word(k); ref_mem[k] = init_word(k); sram3[k] = init_word(k);
    end

    // reset state, with requests already pending
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h4;
    #12;
    check("rst_i_gnt", {31'b0, i_gnt}, 32'd0);
    check("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
    check("rst_m_en", {31'b0, m_en}, 32'd0);
    check("rst_m_we", {31'b0, m_we}, 32'd0);
    check("rst_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; rst3_n = 1'b1; mon_on = 1;

    // I-only back-to-back fetches
    i_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_addr = k * 4;
      cycle();
    end
    i_req = 1'b0;
    cycle();

    // D write then D read of the same word
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
    cycle();
    d_we = 1'b0;
    cycle();
    d_req = 1'b0;
    cycle(); cycle();
    check("d_readback", d_rdata, 32'hDEAD_BEEF);

    // Contention alternates under round-robin
    i_addr = 32'h40; d_addr = 32'h80;
    both_busy(8);

    // Starvation override: round-robin pinned to favour D
    rr_forced = 1; m_rr = 1'b0;
    force dut.rr_last = SRC_I;
    i_addr = 32'h200; d_addr = 32'h300;
    both_busy(5);
    release dut.rr_last;
    rr_forced = 0; m_rr = 1'b0;
    i_req = 1'b1; i_addr = 32'h20;
    settle();

`ifdef LOADER_PORT_EN
    // Loader wins over both, then I reads back the preloaded word
    l_req = 1'b1; l_addr = 32'h0; l_wdata = 32'hC0DE_F00D;
    i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
    settle();
    cycle(); cycle();
    check("loader_readback", i_rdata, 32'hC0DE_F00D);
`endif

    // Randomised traffic with aliased high address bits
    for (int k = 0; k < 300; k++) begin
      cycle();
      if (!i_req || g_i) begin
        i_req  = 1'($urandom_range(0, 1));
        i_addr = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      end
      if (!d_req || g_d) begin
        d_req   = 1'($urandom_range(0, 1));
        d_we    = 1'($urandom_range(0, 1));
        d_wdata = $urandom;
        d_addr  = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      end
    end
    settle();
    repeat (RD_LAT + 3) cycle();
    check("sb_drain", q.size(), 32'd0);
    mon_on = 0;

    // RD_LAT=3: latency of one read
    i3_req = 1'b1; i3_addr = 32'h8;
    @(negedge clk);
    check("l3_gnt", {31'b0, i3_gnt}, 32'd1);
    @(posedge clk); #1;
    i3_req = 1'b0;
    lat = 0; seen = 0;
    for (int n = 1; n <= 8 && !seen; n++) begin
      @(negedge clk);
      if (i3_rvalid) begin lat = n; seen = 1; end
    end
    check("l3_latency", lat, 32'd3);
    check("l3_data", i3_rdata, init_word(2));

    // RD_LAT=3: two reads in flight when reset hits
    @(posedge clk); #1;
    i3_req = 1'b1; i3_addr = 32'h0;
    cycle();
    i3_addr = 32'h4;
    cycle();
    rst3_n = 1'b0; d3_req = 1'b1;
    @(negedge clk);
    check("r3_i_gnt", {31'b0, i3_gnt}, 32'd0);
    check("r3_d_gnt", {31'b0, d3_gnt}, 32'd0);
    check("r3_m_en", {31'b0, m3_en}, 32'd0);
    check("r3_rvalid", {30'b0, i3_rvalid, d3_rvalid}, 32'd0);
    check("r3_i_rdata", i3_rdata, 32'd0);
    @(posedge clk); #1;
    i3_req = 1'b0; d3_req = 1'b0; rst3_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (i3_rvalid || d3_rvalid) seen = 1;
    end
    check("r3_no_rvalid", {31'b0, seen}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
